// File: rtl/sap2_pkg.sv
// Shared definitions for the sap2 host master: FSM states, rw encoding and
// the sap1 window map used when instantiating sap2.
package sap2_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} sap2_state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam logic [31:0] SAP2_WIN0_BASE = 32'hA000_0000;
  localparam logic [31:0] SAP2_WIN1_BASE = 32'hB000_0000;
  localparam logic [31:0] SAP2_WIN_SIZE  = 32'h1000_0000;

endpackage

// File: rtl/sap2_host_master_if.sv
// Request, host bus and response signals of the sap2 host master.
interface sap2_host_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_vld;
  logic              req_rdy;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              host_cmd_vld;
  logic              host_rw;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data_w;
  logic [DATA_W-1:0] host_data_r;
  logic              host_rd_vld;

  logic              rsp_vld;
  logic              rsp_rdy;
  logic              rsp_rw;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              stray_rd;

  modport master (
    input  req_vld, req_rw, req_addr, req_wdata,
    output req_rdy,
    output host_cmd_vld, host_rw, host_addr, host_data_w,
    input  host_data_r, host_rd_vld,
    output rsp_vld, rsp_rw, rsp_rdata, rsp_err, stray_rd,
    input  rsp_rdy
  );

  modport slave (
    output req_vld, req_rw, req_addr, req_wdata,
    input  req_rdy,
    input  host_cmd_vld, host_rw, host_addr, host_data_w,
    output host_data_r, host_rd_vld,
    input  rsp_vld, rsp_rw, rsp_rdata, rsp_err, stray_rd,
    output rsp_rdy
  );
endinterface

// File: rtl/sap2_req_fifo.sv
// Request FIFO; pointers carry an extra wrap bit to tell full from empty.
module sap2_req_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full_nxt
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q, wptr_d, rptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full, do_push, do_pop;

  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign wptr_d   = wptr_q + {{AW{1'b0}}, do_push};
  assign rptr_d   = rptr_q + {{AW{1'b0}}, do_pop};
  // lets the owner register req_rdy so it is a clean flop output
  assign full_nxt = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  assign dout     = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/sap2_host_master.sv
// Upstream command master for sap2: buffers requests, pre-decodes the sap1
// windows, runs one host cycle at a time and returns one response per request.
module sap2_host_master
  import sap2_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter int                TIMEOUT    = 16,
  parameter logic [ADDR_W-1:0] WIN0_BASE  = ADDR_W'(SAP2_WIN0_BASE),
  parameter logic [ADDR_W-1:0] WIN1_BASE  = ADDR_W'(SAP2_WIN1_BASE),
  parameter logic [ADDR_W-1:0] WIN_SIZE   = ADDR_W'(SAP2_WIN_SIZE)
) (
  input logic                clk,
  input logic                reset,
  sap2_host_master_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  sap2_state_e       state_q, state_d;
  req_t              push_d, head;
  logic              empty, full_nxt, push, pop, hit, tmo;
  logic              rdy_q, cmd_vld_q, host_rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rsp_rdata_q;
  logic              rsp_vld_q, rsp_rw_q, rsp_err_q, stray_q;
  logic [TW-1:0]     timer_q;

  function automatic logic in_win(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] off;
    off = a - base;
    return off < WIN_SIZE;
  endfunction

  assign push   = bus.req_vld && rdy_q;
  assign push_d = '{rw: bus.req_rw, addr: bus.req_addr, wdata: bus.req_wdata};
  assign hit    = in_win(head.addr, WIN0_BASE) || in_win(head.addr, WIN1_BASE);
  assign tmo    = (timer_q == TW'(TIMEOUT - 1));

  sap2_req_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .din      (push_d),
    .pop      (pop),
    .dout     (head),
    .empty    (empty),
    .full_nxt (full_nxt)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if (!empty) begin
                 pop     = 1'b1;
                 state_d = hit ? ISSUE : RESP;
               end
      ISSUE:   state_d = (host_rw_q == RW_WRITE) ? RESP : WAIT_RD;
      WAIT_RD: if (bus.host_rd_vld || tmo) state_d = RESP;
      RESP:    if (bus.rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      rdy_q       <= 1'b0;
      cmd_vld_q   <= 1'b0;
      host_rw_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rw_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      stray_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= !full_nxt;
      cmd_vld_q <= (state_d == ISSUE);
      rsp_vld_q <= (state_d == RESP);
      timer_q   <= (state_q == WAIT_RD) ? timer_q + 1'b1 : '0;
      if (pop) begin
        rsp_rw_q    <= head.rw;
        rsp_rdata_q <= '0;
        rsp_err_q   <= !hit;
        // rejected requests never disturb the bus lines
        if (hit) begin
          host_rw_q <= head.rw;
          addr_q    <= head.addr;
          wdata_q   <= head.wdata;
        end
      end
      if (state_q == WAIT_RD) begin
        if (bus.host_rd_vld) begin
          rsp_rdata_q <= bus.host_data_r;
          rsp_err_q   <= 1'b0;
        end else if (tmo) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
      end
      if (bus.host_rd_vld && state_q != WAIT_RD) stray_q <= 1'b1;
    end
  end

  assign bus.req_rdy      = rdy_q;
  assign bus.host_cmd_vld = cmd_vld_q;
  assign bus.host_rw      = host_rw_q;
  assign bus.host_addr    = addr_q;
  assign bus.host_data_w  = wdata_q;
  assign bus.rsp_vld      = rsp_vld_q;
  assign bus.rsp_rw       = rsp_rw_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.stray_rd     = stray_q;
endmodule

// File: tb/tb_sap2_host_master.sv
// Bench for sap2_host_master: directed latency/boundary scenarios plus random
// traffic against a queue-based request/response model and a sap2 stand-in.
module tb_sap2_host_master;
  import sap2_pkg::*;

  localparam int TMO = 16;

  typedef struct {logic rw; logic [31:0] rdata; logic err;} rsp_t;
  typedef struct {logic rw; logic [31:0] addr; logic [31:0] wdata;} bus_t;
  typedef struct {int dly; logic [31:0] data;} rd_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sap2_host_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sap2_host_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   auto_host = 1'b0;
  logic d_rd_vld = 1'b0, a_rd_vld = 1'b0;
  logic [31:0] d_data = '0, a_data = '0;
  rsp_t exp_q[$];
  bus_t bus_q[$];
  rd_t  rd_q[$];

  assign bus.host_rd_vld = d_rd_vld | a_rd_vld;
  assign bus.host_data_r = a_rd_vld ? a_data : d_data;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Only the two sap1 windows (top nibble A or B) reach the bus.
  function automatic bit in_win(input logic [31:0] a);
    return a[31:28] == 4'hA || a[31:28] == 4'hB;
  endfunction

  task automatic model_accept(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input int dly, input logic [31:0] rdata);
    if (!in_win(addr)) exp_q.push_back('{rw, 32'h0, 1'b1});
    else begin
      bus_q.push_back('{rw, addr, wdata});
      if (rw == RW_WRITE) exp_q.push_back('{rw, 32'h0, 1'b0});
      else begin
        rd_q.push_back('{dly, rdata});
        exp_q.push_back('{rw, (dly > 0) ? rdata : 32'h0, (dly > 0) ? 1'b0 : 1'b1});
      end
    end
  endtask

  // sap2 stand-in: checks each strobe, answers reads after the planned delay
  initial begin : host_model
    bus_t b;
    rd_t  r;
    forever begin
      @(posedge clk); #1;
      if (auto_host && bus.host_cmd_vld) begin
        n_tests++;
        if (bus_q.size() == 0) begin
          n_fail++;
          $display("FAIL bus_strobe: unexpected strobe addr=%h", bus.host_addr);
        end else begin
          b = bus_q.pop_front();
          if (bus.host_rw !== b.rw || bus.host_addr !== b.addr || (b.rw && bus.host_data_w !== b.wdata)) begin
            n_fail++;
            $display("FAIL bus_strobe: got rw=%b addr=%h data=%h, want rw=%b addr=%h data=%h",
                     bus.host_rw, bus.host_addr, bus.host_data_w, b.rw, b.addr, b.wdata);
          end
          if (b.rw == RW_READ && rd_q.size() != 0) begin
            r = rd_q.pop_front();
            if (r.dly > 0) begin
              repeat (r.dly) step();
              a_data = r.data; a_rd_vld = 1'b1;
              step();
              a_rd_vld = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.req_rdy, bus.host_cmd_vld, bus.host_rw, bus.host_addr, bus.host_data_w, bus.rsp_vld,
         bus.rsp_rw, bus.rsp_rdata, bus.rsp_err, bus.stray_rd} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    reset = 1'b1;
    step();
    n_tests++;
    if (bus.req_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", bus.req_rdy); end
  endtask

  task automatic test_write();
    bus.req_vld = 1; bus.req_rw = RW_WRITE; bus.req_addr = 32'hA000_0010; bus.req_wdata = 32'h1234_5678;
    step(); bus.req_vld = 0;                                   // cycle 1
    n_tests++;
    if (bus.host_cmd_vld !== 1'b0) begin n_fail++; $display("FAIL wr_c1: cmd_vld=%b want 0", bus.host_cmd_vld); end
    step();                                                    // cycle 2
    n_tests++;
    if (bus.host_cmd_vld !== 1'b1 || bus.host_rw !== 1'b1 || bus.host_addr !== 32'hA000_0010 ||
        bus.host_data_w !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wr_strobe: got vld=%b rw=%b addr=%h data=%h", bus.host_cmd_vld,
                         bus.host_rw, bus.host_addr, bus.host_data_w);
    end
    step();                                                    // cycle 3
    n_tests++;
    if (bus.host_cmd_vld !== 1'b0 || bus.rsp_vld !== 1'b1 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'h0 || bus.rsp_rw !== 1'b1) begin
      n_fail++; $display("FAIL wr_rsp: got cmd=%b vld=%b err=%b rdata=%h rw=%b, want 0 1 0 0 1",
                         bus.host_cmd_vld, bus.rsp_vld, bus.rsp_err, bus.rsp_rdata, bus.rsp_rw);
    end
    bus.rsp_rdy = 1; step(); bus.rsp_rdy = 0;
    n_tests++;
    if (bus.rsp_vld !== 1'b0) begin n_fail++; $display("FAIL wr_done: rsp_vld=%b want 0", bus.rsp_vld); end
  endtask

  task automatic test_read();
    bus.req_vld = 1; bus.req_rw = RW_READ; bus.req_addr = 32'hB000_0004; bus.req_wdata = 32'h0;
    step(); bus.req_vld = 0;
    step();                                                    // cycle 2
    n_tests++;
    if (bus.host_cmd_vld !== 1'b1 || bus.host_rw !== 1'b0 || bus.host_addr !== 32'hB000_0004) begin
      n_fail++; $display("FAIL rd_strobe: got vld=%b rw=%b addr=%h", bus.host_cmd_vld, bus.host_rw, bus.host_addr);
    end
    step(); step(); step();                                    // cycle 5
    d_rd_vld = 1; d_data = 32'hCAFE_F00D;
    n_tests++;
    if (bus.rsp_vld !== 1'b0) begin n_fail++; $display("FAIL rd_early: rsp_vld=%b want 0", bus.rsp_vld); end
    step(); d_rd_vld = 0; d_data = 32'h0;                      // cycle 6
    n_tests++;
    if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_F00D || bus.rsp_err !== 1'b0 || bus.rsp_rw !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got vld=%b rdata=%h err=%b rw=%b, want 1 cafef00d 0 0",
                         bus.rsp_vld, bus.rsp_rdata, bus.rsp_err, bus.rsp_rw);
    end
    bus.rsp_rdy = 1; step(); bus.rsp_rdy = 0;
  endtask

  task automatic test_decode_err();
    bus.req_vld = 1; bus.req_rw = RW_READ; bus.req_addr = 32'hC000_0000;
    step(); bus.req_vld = 0;
    n_tests++;
    if (bus.host_cmd_vld !== 1'b0 || bus.rsp_vld !== 1'b0) begin
      n_fail++; $display("FAIL dec_c1: cmd=%b rsp_vld=%b want 0 0", bus.host_cmd_vld, bus.rsp_vld);
    end
    step();                                                    // cycle 2
    n_tests++;
    if (bus.host_cmd_vld !== 1'b0 || bus.rsp_vld !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL dec_rsp: got cmd=%b vld=%b err=%b rdata=%h, want 0 1 1 0",
                         bus.host_cmd_vld, bus.rsp_vld, bus.rsp_err, bus.rsp_rdata);
    end
    n_tests++;
    if (bus.host_addr !== 32'hB000_0004) begin
      n_fail++; $display("FAIL dec_hold: host_addr=%h want b0000004", bus.host_addr);
    end
    bus.rsp_rdy = 1; step(); bus.rsp_rdy = 0;
    n_tests++;
    if (bus.host_cmd_vld !== 1'b0 || bus.rsp_vld !== 1'b0) begin
      n_fail++; $display("FAIL dec_after: cmd=%b rsp_vld=%b want 0 0", bus.host_cmd_vld, bus.rsp_vld);
    end
  endtask

  // rd_at = WAIT_RD cycle (1-based) carrying rd_vld, 0 = never
  task automatic test_timeout(input int rd_at);
    logic [31:0] data;
    data = $urandom;
    bus.req_vld = 1; bus.req_rw = RW_READ; bus.req_addr = 32'hA000_0400;
    step(); bus.req_vld = 0;
    step();                                                    // strobe cycle
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k == rd_at) begin d_rd_vld = 1; d_data = data; end
      n_tests++;
      if (bus.rsp_vld !== 1'b0) begin n_fail++; $display("FAIL tmo_early_%0d: rsp_vld=1 at wait cycle %0d", rd_at, k); end
    end
    step(); d_rd_vld = 0; d_data = 32'h0;
    n_tests++;
    if (bus.rsp_vld !== 1'b1 || bus.rsp_err !== (rd_at == 0) || bus.rsp_rdata !== ((rd_at == 0) ? 32'h0 : data)) begin
      n_fail++; $display("FAIL tmo_rsp_%0d: got vld=%b err=%b rdata=%h, want 1 %b %h", rd_at, bus.rsp_vld,
                         bus.rsp_err, bus.rsp_rdata, rd_at == 0, (rd_at == 0) ? 32'h0 : data);
    end
    bus.rsp_rdy = 1; step(); bus.rsp_rdy = 0;
  endtask

  task automatic test_back_to_back();
    bus_t tbl[6];
    rd_t  rtbl[6];
    int   i = 0;
    bit   acc, stall = 0;
    rsp_t e;
    logic [33:0] held = '0;
    for (int k = 0; k < 6; k++) begin
      tbl[k].rw = k[0] ? RW_READ : RW_WRITE;
      tbl[k].addr = ((k < 3) ? 32'hA000_0100 : 32'hB000_0100) + 32'(k * 4);
      tbl[k].wdata = $urandom;
      rtbl[k].dly = 2; rtbl[k].data = $urandom;
    end
    auto_host = 1;
    for (int c = 0; c < 400 && (i < 6 || exp_q.size() != 0); c++) begin
      bus.rsp_rdy = (c >= 30);
      if (c == 29) begin
        n_tests++;
        if (i !== 5 || bus.req_rdy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_backpressure: accepted=%0d req_rdy=%b, want 5 0", i, bus.req_rdy);
        end
      end
      acc = 0;
      if (i < 6) begin
        bus.req_vld = 1; bus.req_rw = tbl[i].rw; bus.req_addr = tbl[i].addr; bus.req_wdata = tbl[i].wdata;
        acc = bus.req_rdy;
        if (acc) model_accept(tbl[i].rw, tbl[i].addr, tbl[i].wdata, rtbl[i].dly, rtbl[i].data);
      end
      if (bus.rsp_vld && stall) begin
        n_tests++;
        if ({bus.rsp_rw, bus.rsp_err, bus.rsp_rdata} !== held) begin
          n_fail++; $display("FAIL b2b_hold: rsp changed to %h from %h while stalled",
                             {bus.rsp_rw, bus.rsp_err, bus.rsp_rdata}, held);
        end
      end
      stall = bus.rsp_vld && !bus.rsp_rdy;
      held  = {bus.rsp_rw, bus.rsp_err, bus.rsp_rdata};
      if (bus.rsp_vld && bus.rsp_rdy) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_rsp: unexpected response"); end
        else begin
          e = exp_q.pop_front();
          if (bus.rsp_rw !== e.rw || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL b2b_rsp: got rw=%b rdata=%h err=%b, want rw=%b rdata=%h err=%b",
                               bus.rsp_rw, bus.rsp_rdata, bus.rsp_err, e.rw, e.rdata, e.err);
          end
        end
      end
      step();
      if (acc) begin i++; bus.req_vld = 0; end
    end
    bus.rsp_rdy = 0; auto_host = 0;
    n_tests++;
    if (i != 6 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: accepted=%0d pending=%0d, want 6 0", i, exp_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] edge_addr [7] = '{32'h9FFF_FFFF, 32'hA000_0000, 32'hAFFF_FFFF, 32'hB000_0000,
                                   32'hBFFF_FFFF, 32'hC000_0000, 32'h0000_0000};
    logic [3:0]  nib [6] = '{4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'h9};
    int   n_sent = 0, dly = 0;
    bit   hold = 0, acc, stall = 0;
    logic [31:0] rdata = '0;
    logic [33:0] held = '0;
    rsp_t e;
    auto_host = 1;
    for (int c = 0; c < 5000 && (n_sent < 60 || exp_q.size() != 0); c++) begin
      if (!hold && n_sent < 60 && $urandom_range(0, 2) != 0) begin
        bus.req_rw    = 1'($urandom_range(0, 1));
        bus.req_addr  = (n_sent < 7) ? edge_addr[n_sent] : {nib[$urandom_range(0, 5)], 28'($urandom)};
        bus.req_wdata = $urandom;
        dly   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO);
        rdata = $urandom;
        bus.req_vld = 1; hold = 1;
      end
      acc = hold && bus.req_rdy;
      if (acc) model_accept(bus.req_rw, bus.req_addr, bus.req_wdata, dly, rdata);
      bus.rsp_rdy = ($urandom_range(0, 3) != 0);
      if (bus.rsp_vld && stall) begin
        n_tests++;
        if ({bus.rsp_rw, bus.rsp_err, bus.rsp_rdata} !== held) begin
          n_fail++; $display("FAIL rnd_hold: rsp changed to %h from %h while stalled",
                             {bus.rsp_rw, bus.rsp_err, bus.rsp_rdata}, held);
        end
      end
      stall = bus.rsp_vld && !bus.rsp_rdy;
      held  = {bus.rsp_rw, bus.rsp_err, bus.rsp_rdata};
      if (bus.rsp_vld && bus.rsp_rdy) begin
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_rsp: unexpected response"); end
        else begin
          e = exp_q.pop_front();
          if (bus.rsp_rw !== e.rw || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
            n_fail++; $display("FAIL rnd_rsp: got rw=%b rdata=%h err=%b, want rw=%b rdata=%h err=%b",
                               bus.rsp_rw, bus.rsp_rdata, bus.rsp_err, e.rw, e.rdata, e.err);
          end
        end
      end
      step();
      if (acc) begin hold = 0; bus.req_vld = 0; n_sent++; end
    end
    bus.rsp_rdy = 0; auto_host = 0;
    n_tests++;
    if (n_sent != 60 || exp_q.size() != 0 || bus_q.size() != 0 || bus.stray_rd !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain: sent=%0d pending=%0d bus_pending=%0d stray=%b, want 60 0 0 0",
                         n_sent, exp_q.size(), bus_q.size(), bus.stray_rd);
    end
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    bus.req_vld = 1; bus.req_rw = RW_READ; bus.req_addr = 32'hA000_0800;
    step(); bus.req_addr = 32'hB000_0800;                      // second read queued behind
    step(); bus.req_vld = 0;
    step(); step();                                            // in WAIT_RD
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.req_rdy, bus.host_cmd_vld, bus.host_addr, bus.rsp_vld, bus.rsp_err, bus.stray_rd} !== '0) begin
      n_fail++; $display("FAIL mid_reset: outputs not cleared rdy=%b cmd=%b addr=%h rsp=%b stray=%b",
                         bus.req_rdy, bus.host_cmd_vld, bus.host_addr, bus.rsp_vld, bus.stray_rd);
    end
    step(); reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.host_cmd_vld !== 1'b0 || bus.rsp_vld !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad || bus.req_rdy !== 1'b1) begin
      n_fail++; $display("FAIL mid_quiet: activity after reset=%b req_rdy=%b, want 0 1", bad, bus.req_rdy);
    end
    d_rd_vld = 1; step(); d_rd_vld = 0;
    n_tests++;
    if (bus.stray_rd !== 1'b1 || bus.rsp_vld !== 1'b0) begin
      n_fail++; $display("FAIL stray_rd: stray=%b rsp_vld=%b, want 1 0", bus.stray_rd, bus.rsp_vld);
    end
  endtask

  initial begin
    bus.req_vld = 0; bus.req_rw = 0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_rdy = 0;
    test_reset();
    test_write();
    test_read();
    test_decode_err();
    test_timeout(0);
    test_timeout(TMO);
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sap2_host_master.md
Name: sap2_host_master

Overview:
Upstream command master for the sap2 top: converts a buffered request stream (valid/ready) into host bus cycles (cmd_vld/addr/data_w/rw out, data_r/rd_vld in) and returns one response per request.
- Drives sap2's host port directly.
- Serialises accesses: one outstanding host cycle at a time.
- Pre-decodes the two sap1 windows and rejects out-of-window addresses without touching the bus.
- Times out reads that never return rd_vld.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
TIMEOUT, 16, WAIT_RD cycles before error (>=2)
WIN0_BASE, 32'hA000_0000, base of sap1 instance 1 window
WIN1_BASE, 32'hB000_0000, base of sap1 instance 2 window
WIN_SIZE, 32'h1000_0000, size of each window

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
req_vld  in  1  request valid
req_rdy  out  1  request accepted when req_vld&&req_rdy
req_rw  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
host_cmd_vld  out  1  one-cycle command strobe to sap2
host_rw  out  1  1=write, 0=read
host_addr  out  ADDR_W  bus address
host_data_w  out  DATA_W  bus write data
host_data_r  in  DATA_W  read data from sap2
host_rd_vld  in  1  read data valid
rsp_vld  out  1  response valid
rsp_rdy  in  1  response consumed
rsp_rw  out  1  echo of request rw
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  1 = decode error or timeout
stray_rd  out  1  sticky: rd_vld seen outside WAIT_RD

Behaviour:
- Reset (reset=0, async): FIFO empty, FSM=IDLE, timer=0. All outputs 0, except req_rdy=1 once reset deasserts.
- FIFO: req_rdy = !full. No push when full, even if a pop happens in the same cycle. Pointers wrap modulo FIFO_DEPTH with an extra wrap bit for full/empty.
- In-window test: (addr - BASE) < WIN_SIZE, unsigned, full ADDR_W, evaluated for either window.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into cur_{rw,addr,wdata}. Out-of-window -> RESP with err=1, rdata=0. Otherwise -> ISSUE.
  - ISSUE: host_cmd_vld=1 for exactly this one cycle. host_rw/addr/data_w = cur values. Write -> RESP (err=0). Read -> WAIT_RD, timer=0.
  - WAIT_RD: timer++ each cycle.
    - host_rd_vld=1 -> capture host_data_r into rsp_rdata, err=0, -> RESP.
    - Otherwise timer==TIMEOUT-1 -> err=1, rdata=0, -> RESP.
    - If rd_vld and timeout coincide, data wins (err=0).
  - RESP: rsp_vld=1. rsp_rw/rdata/err held stable until rsp_rdy. Handshake -> IDLE.
- host_addr/data_w/rw hold their last value outside ISSUE; they are not cleared.
- All outputs come from flops.
- Latency with FIFO empty and FSM idle, request handshake in cycle 0:
  - Pop in cycle 1; host_cmd_vld in cycle 2.
  - Write response rsp_vld in cycle 3.
  - Read: rsp_vld the cycle after rd_vld.
  - Decode error: rsp_vld in cycle 2, with no bus cycle.
- Throughput: at most one request per 3 cycles. Requests keep being accepted while the FSM is busy until the FIFO is full.
- host_rd_vld while not in WAIT_RD: ignored for data; sets stray_rd (cleared only by reset).
- Reset mid-operation: aborts any host cycle; no response is issued for the in-flight or queued requests.

Decomposition:
- Package sap2_pkg: FSM state enum (IDLE, ISSUE, WAIT_RD, RESP), RW_WRITE/RW_READ constants, window base/size constants shared with sap2 instantiation.
- Sub-module sap2_req_fifo: synchronous FIFO of {rw,addr,wdata}, parameters WIDTH/DEPTH, ports push/pop/full/empty.

Test Plan:
- Write 0xA000_0010, data 0x1234_5678 -> host_cmd_vld pulse 1 cycle with rw=1, addr/data matching; rsp_vld cycle 3, rsp_err=0, rsp_rdata=0.
- Read 0xB000_0004, sap2 returns rd_vld with 0xCAFE_F00D 3 cycles after strobe -> rsp_vld next cycle, rdata=0xCAFE_F00D, err=0.
- Read 0xC000_0000 -> no host_cmd_vld ever; rsp_vld cycle 2, err=1, rdata=0.
- Read in-window, rd_vld never asserted -> rsp_err=1 after 16 WAIT_RD cycles; separately, rd_vld on cycle 16 -> err=0, data returned.
- Push 6 back-to-back requests with rsp_rdy=0 -> req_rdy drops after 4 queued plus 1 in flight; rsp held stable; release rsp_rdy -> all 6 responses in order.
- Assert reset=0 during WAIT_RD -> outputs 0 immediately (async), FIFO empty, no response; a stray rd_vld afterwards sets stray_rd=1.
